// File: rtl/bp_me_pkg.sv
// Shared definitions for the BedRock memory-side stream arbiter and its tracker.
package bp_me_pkg;

    localparam int dword_width_gp      = 64;
    localparam int mem_header_width_lp = 64;

    typedef enum logic [0:0] {
        e_arb_rr    = 1'b0,
        e_arb_fixed = 1'b1
    } bp_me_arb_mode_e;

    // Index width that stays at least one bit for degenerate sizes
    function automatic int lg_safe(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bp_me_stream_arb_tracker.sv
// Issue-order FIFO of channel indices; head names the owner of the next memory response.
module bp_me_stream_arb_tracker
    import bp_me_pkg::*;
#(
    parameter int width_p = 2,
    parameter int els_p   = 8
)(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               push_i,
    input  logic [width_p-1:0] data_i,
    input  logic               pop_i,
    output logic               full_o,
    output logic               empty_o,
    output logic [width_p-1:0] head_o
);

    localparam int ptr_w_lp = lg_safe(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cnt_w_lp-1:0] count_q, count_d;
    logic                push_ok, pop_ok;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == cnt_w_lp'(els_p));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wptr_d  = push_ok ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = pop_ok  ? ptr_inc(rptr_q) : rptr_q;
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: head is only consumed while count_q is non-zero
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/bp_cce_mem_stream_arb.sv
// N-to-1 BedRock stream arbiter: message-locked command merge, in-order response return.
module bp_cce_mem_stream_arb
    import bp_me_pkg::*;
#(
    parameter int              num_cce_p      = 4,
    parameter int              header_width_p = mem_header_width_lp,
    parameter int              data_width_p   = dword_width_gp,
    parameter int              outstanding_p  = 8,
    parameter bp_me_arb_mode_e arb_mode_p     = e_arb_rr
)(
    input  logic                                clk_i,
    input  logic                                reset_i,

    input  logic [num_cce_p*header_width_p-1:0] cce_cmd_header_i,
    input  logic [num_cce_p*data_width_p-1:0]   cce_cmd_data_i,
    input  logic [num_cce_p-1:0]                cce_cmd_v_i,
    output logic [num_cce_p-1:0]                cce_cmd_ready_and_o,
    input  logic [num_cce_p-1:0]                cce_cmd_last_i,

    output logic [header_width_p-1:0]           cce_resp_header_o,
    output logic [data_width_p-1:0]             cce_resp_data_o,
    output logic [num_cce_p-1:0]                cce_resp_v_o,
    input  logic [num_cce_p-1:0]                cce_resp_ready_and_i,
    output logic                                cce_resp_last_o,

    output logic [header_width_p-1:0]           mem_cmd_header_o,
    output logic [data_width_p-1:0]             mem_cmd_data_o,
    output logic                                mem_cmd_v_o,
    output logic                                mem_cmd_last_o,
    input  logic                                mem_cmd_ready_and_i,

    input  logic [header_width_p-1:0]           mem_resp_header_i,
    input  logic [data_width_p-1:0]             mem_resp_data_i,
    input  logic                                mem_resp_v_i,
    input  logic                                mem_resp_last_i,
    output logic                                mem_resp_ready_and_o
);

    localparam int lg_cce_lp  = lg_safe(num_cce_p);
    localparam int lg1_cce_lp = lg_cce_lp + 1;

    localparam logic [0:0] st_idle_lp  = 1'b0;
    localparam logic [0:0] st_burst_lp = 1'b1;

    localparam logic [num_cce_p-1:0] ch_one_lp = {{(num_cce_p-1){1'b0}}, 1'b1};

    logic [0:0]                lock_q, lock_d;
    logic [lg_cce_lp-1:0]      grant_q, grant_d;
    logic [lg_cce_lp-1:0]      rr_ptr_q, rr_ptr_d;

    logic [header_width_p-1:0] cmd_hdr_arr  [num_cce_p];
    logic [data_width_p-1:0]   cmd_data_arr [num_cce_p];
    logic [lg1_cce_lp-1:0]     scan_sum     [num_cce_p];
    logic [lg_cce_lp-1:0]      scan_idx     [num_cce_p];

    logic [lg_cce_lp-1:0]      winner, sel, sel_inc;
    logic                      any_v, cmd_en, cmd_hs, push;
    logic                      trk_full, trk_empty, pop;
    logic [lg_cce_lp-1:0]      trk_head;

    // scan_idx[k] is the channel examined k-th: rotated from rr_ptr_q, or identity in fixed mode
    genvar gi;
    generate
        for (gi = 0; gi < num_cce_p; gi++) begin : g_ch
            assign cmd_hdr_arr[gi]  = cce_cmd_header_i[gi*header_width_p +: header_width_p];
            assign cmd_data_arr[gi] = cce_cmd_data_i[gi*data_width_p +: data_width_p];
            assign scan_sum[gi]     = {1'b0, rr_ptr_q} + lg1_cce_lp'(gi);
            assign scan_idx[gi]     = (arb_mode_p == e_arb_fixed) ? lg_cce_lp'(gi)
                                    : (scan_sum[gi] >= lg1_cce_lp'(num_cce_p))
                                      ? lg_cce_lp'(scan_sum[gi] - lg1_cce_lp'(num_cce_p))
                                      : scan_sum[gi][lg_cce_lp-1:0];
        end
    endgenerate

    // Walk from last to first so the earliest requester in scan order is what remains
    always_comb begin
        winner = '0;
        any_v  = 1'b0;
        for (int i = num_cce_p - 1; i >= 0; i--) begin
            if (cce_cmd_v_i[scan_idx[i]]) begin
                winner = scan_idx[i];
                any_v  = 1'b1;
            end
        end
    end

    assign sel     = (lock_q == st_burst_lp) ? grant_q : winner;
    assign sel_inc = (sel == lg_cce_lp'(num_cce_p - 1)) ? '0 : sel + 1'b1;

    // A new message may start only with tracker room; a locked burst always continues
    assign cmd_en = ~reset_i & ((lock_q == st_burst_lp) | (any_v & ~trk_full));

    assign mem_cmd_header_o    = cmd_hdr_arr[sel];
    assign mem_cmd_data_o      = cmd_data_arr[sel];
    assign mem_cmd_last_o      = cce_cmd_last_i[sel];
    assign mem_cmd_v_o         = cmd_en & cce_cmd_v_i[sel];
    assign cce_cmd_ready_and_o = cmd_en ? ({num_cce_p{mem_cmd_ready_and_i}} & (ch_one_lp << sel)) : '0;

    assign cmd_hs = mem_cmd_v_o & mem_cmd_ready_and_i;
    assign push   = cmd_hs & (lock_q == st_idle_lp);

    always_comb begin
        lock_d   = lock_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        if (cmd_hs) begin
            if (cce_cmd_last_i[sel]) begin
                lock_d   = st_idle_lp;
                rr_ptr_d = sel_inc;
            end else begin
                lock_d   = st_burst_lp;
                grant_d  = sel;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            lock_q   <= st_idle_lp;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            lock_q   <= lock_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    bp_me_stream_arb_tracker #(
        .width_p (lg_cce_lp),
        .els_p   (outstanding_p)
    ) u_tracker (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push),
        .data_i  (sel),
        .pop_i   (pop),
        .full_o  (trk_full),
        .empty_o (trk_empty),
        .head_o  (trk_head)
    );

    assign cce_resp_header_o    = mem_resp_header_i;
    assign cce_resp_data_o      = mem_resp_data_i;
    assign cce_resp_last_o      = mem_resp_last_i;
    assign cce_resp_v_o         = (~trk_empty & mem_resp_v_i) ? (ch_one_lp << trk_head) : '0;
    assign mem_resp_ready_and_o = ~trk_empty & cce_resp_ready_and_i[trk_head];
    assign pop                  = mem_resp_v_i & mem_resp_ready_and_o & mem_resp_last_i;

    a_resp_when_empty: assert property (@(posedge clk_i) disable iff (reset_i)
        !(mem_resp_v_i && trk_empty));

endmodule

// File: tb/tb_bp_cce_mem_stream_arb.sv
// Directed bench: instance 0 is round-robin (8 outstanding), instance 1 fixed priority (2 outstanding).
module tb_bp_cce_mem_stream_arb;
    import bp_me_pkg::*;

    localparam int N  = 4;
    localparam int HW = mem_header_width_lp;
    localparam int DW = dword_width_gp;

    logic clk;
    logic reset;

    logic [N*HW-1:0] cmd_hdr   [2];
    logic [N*DW-1:0] cmd_data  [2];
    logic [N-1:0]    cmd_v     [2];
    logic [N-1:0]    cmd_rdy   [2];
    logic [N-1:0]    cmd_last  [2];
    logic [HW-1:0]   resp_hdr  [2];
    logic [DW-1:0]   resp_data [2];
    logic [N-1:0]    resp_v    [2];
    logic [N-1:0]    resp_rdy  [2];
    logic            resp_last [2];
    logic [HW-1:0]   mc_hdr    [2];
    logic [DW-1:0]   mc_data   [2];
    logic            mc_v      [2];
    logic            mc_last   [2];
    logic            mc_rdy    [2];
    logic [HW-1:0]   mr_hdr    [2];
    logic [DW-1:0]   mr_data   [2];
    logic            mr_v      [2];
    logic            mr_last   [2];
    logic            mr_rdy    [2];

    int n_checks = 0;
    int n_fail   = 0;

    bp_cce_mem_stream_arb #(
        .num_cce_p(N), .header_width_p(HW), .data_width_p(DW),
        .outstanding_p(8), .arb_mode_p(e_arb_rr)
    ) u_rr (
        .clk_i(clk), .reset_i(reset),
        .cce_cmd_header_i(cmd_hdr[0]), .cce_cmd_data_i(cmd_data[0]),
        .cce_cmd_v_i(cmd_v[0]), .cce_cmd_ready_and_o(cmd_rdy[0]), .cce_cmd_last_i(cmd_last[0]),
        .cce_resp_header_o(resp_hdr[0]), .cce_resp_data_o(resp_data[0]),
        .cce_resp_v_o(resp_v[0]), .cce_resp_ready_and_i(resp_rdy[0]), .cce_resp_last_o(resp_last[0]),
        .mem_cmd_header_o(mc_hdr[0]), .mem_cmd_data_o(mc_data[0]), .mem_cmd_v_o(mc_v[0]),
        .mem_cmd_last_o(mc_last[0]), .mem_cmd_ready_and_i(mc_rdy[0]),
        .mem_resp_header_i(mr_hdr[0]), .mem_resp_data_i(mr_data[0]), .mem_resp_v_i(mr_v[0]),
        .mem_resp_last_i(mr_last[0]), .mem_resp_ready_and_o(mr_rdy[0])
    );

    bp_cce_mem_stream_arb #(
        .num_cce_p(N), .header_width_p(HW), .data_width_p(DW),
        .outstanding_p(2), .arb_mode_p(e_arb_fixed)
    ) u_fx (
        .clk_i(clk), .reset_i(reset),
        .cce_cmd_header_i(cmd_hdr[1]), .cce_cmd_data_i(cmd_data[1]),
        .cce_cmd_v_i(cmd_v[1]), .cce_cmd_ready_and_o(cmd_rdy[1]), .cce_cmd_last_i(cmd_last[1]),
        .cce_resp_header_o(resp_hdr[1]), .cce_resp_data_o(resp_data[1]),
        .cce_resp_v_o(resp_v[1]), .cce_resp_ready_and_i(resp_rdy[1]), .cce_resp_last_o(resp_last[1]),
        .mem_cmd_header_o(mc_hdr[1]), .mem_cmd_data_o(mc_data[1]), .mem_cmd_v_o(mc_v[1]),
        .mem_cmd_last_o(mc_last[1]), .mem_cmd_ready_and_i(mc_rdy[1]),
        .mem_resp_header_i(mr_hdr[1]), .mem_resp_data_i(mr_data[1]), .mem_resp_v_i(mr_v[1]),
        .mem_resp_last_i(mr_last[1]), .mem_resp_ready_and_o(mr_rdy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %-22s got %0h expected %0h", tag, act, exp);
        end else begin
            $display("ok   %-22s %0h", tag, act);
        end
    endtask

    // Leaves the bench at a falling edge with reset released and all valids low
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            cmd_v[d]    = '0;
            cmd_last[d] = 4'hF;
            mr_v[d]     = 1'b0;
            mr_last[d]  = 1'b1;
            mc_rdy[d]   = 1'b1;
            resp_rdy[d] = 4'hF;
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_oh;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) begin
                cmd_hdr[d][i*HW +: HW]  = 64'hA0 + 64'(i);
                cmd_data[d][i*DW +: DW] = 64'hD0 + 64'(i);
            end
            cmd_v[d]    = '0;
            cmd_last[d] = 4'hF;
            mc_rdy[d]   = 1'b1;
            resp_rdy[d] = 4'hF;
            mr_v[d]     = 1'b0;
            mr_last[d]  = 1'b1;
            mr_hdr[d]   = '0;
            mr_data[d]  = '0;
        end

        // Reset state, during and after reset
        @(negedge clk); #1;
        check("rst mc_v",     64'(mc_v[0]),    0);
        check("rst cmd_rdy",  64'(cmd_rdy[0]), 0);
        check("rst resp_v",   64'(resp_v[0]),  0);
        check("rst mr_rdy",   64'(mr_rdy[0]),  0);
        @(negedge clk);
        reset = 1'b0; #1;
        check("idle mc_v",    64'(mc_v[0]),    0);
        check("idle cmd_rdy", 64'(cmd_rdy[1]), 0);
        check("idle mr_rdy",  64'(mr_rdy[1]),  0);
        @(negedge clk);

        // Reset in the middle of a 4-beat burst from channel 1
        cmd_v[0] = 4'b0010; cmd_last[0] = 4'b0000; #1;
        check("mid beat0 v",   64'(mc_v[0]),    1);
        check("mid beat0 hdr", mc_hdr[0],       64'hA1);
        check("mid beat0 rdy", 64'(cmd_rdy[0]), 4'b0010);
        @(negedge clk); #1;
        check("mid beat1 hdr", mc_hdr[0],       64'hA1);
        @(negedge clk);
        reset = 1'b1; cmd_v[0] = 4'b0011; cmd_last[0] = 4'hF; #1;
        check("mid rst mc_v",  64'(mc_v[0]),    0);
        check("mid rst rdy",   64'(cmd_rdy[0]), 0);
        check("mid rst mr_rdy",64'(mr_rdy[0]),  0);
        check("mid rst resp_v",64'(resp_v[0]),  0);
        @(negedge clk);
        reset = 1'b0; #1;
        check("post rst hdr",  mc_hdr[0],       64'hA0);
        check("post rst rdy",  64'(cmd_rdy[0]), 4'b0001);
        @(negedge clk);
        cmd_v[0] = '0; mr_v[0] = 1'b1; mr_last[0] = 1'b1; mr_hdr[0] = 64'hE0; #1;
        check("trk head resp_v", 64'(resp_v[0]), 4'b0001);
        check("trk head mr_rdy", 64'(mr_rdy[0]), 1);
        check("trk head hdr",    resp_hdr[0],    64'hE0);
        @(negedge clk);
        mr_v[0] = 1'b0; #1;
        check("trk empty mr_rdy", 64'(mr_rdy[0]), 0);

        // Round-robin fairness with four continuous single-beat requesters
        do_reset();
        cmd_v[0] = 4'hF; cmd_last[0] = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_oh = 4'b0001 << (k % 4);
            check($sformatf("rr hdr %0d", k), mc_hdr[0],       64'hA0 + 64'(k % 4));
            check($sformatf("rr rdy %0d", k), 64'(cmd_rdy[0]), 64'(exp_oh));
            @(negedge clk);
        end
        #1;
        check("rr full mc_v", 64'(mc_v[0]),    0);
        check("rr full rdy",  64'(cmd_rdy[0]), 0);

        // Burst lock: channel 2 holds the grant for 8 beats while channel 0 waits
        do_reset();
        for (int b = 0; b < 8; b++) begin
            cmd_v[0]            = (b == 0) ? 4'b0100 : 4'b0101;
            cmd_last[0]         = (b == 7) ? 4'b0101 : 4'b0001;
            cmd_data[0][2*DW +: DW] = 64'(b);
            #1;
            check($sformatf("lock hdr %0d", b),  mc_hdr[0],       64'hA2);
            check($sformatf("lock rdy %0d", b),  64'(cmd_rdy[0]), 4'b0100);
            check($sformatf("lock last %0d", b), 64'(mc_last[0]), (b == 7) ? 1 : 0);
            check($sformatf("lock data %0d", b), mc_data[0],      64'(b));
            @(negedge clk);
        end
        cmd_v[0] = 4'b0001; cmd_data[0][2*DW +: DW] = 64'hD2; #1;
        check("lock next hdr", mc_hdr[0],       64'hA0);
        check("lock next rdy", 64'(cmd_rdy[0]), 4'b0001);
        @(negedge clk);
        cmd_v[0] = '0;

        // Fixed priority and full tracker on the 2-deep instance
        do_reset();
        cmd_v[1] = 4'b1010; #1;
        check("fix 1 wins hdr", mc_hdr[1],       64'hA1);
        check("fix 1 wins rdy", 64'(cmd_rdy[1]), 4'b0010);
        @(negedge clk);
        mc_rdy[1] = 1'b0; #1;
        check("fix 1 again hdr", mc_hdr[1],       64'hA1);
        check("fix stall rdy",   64'(cmd_rdy[1]), 0);
        @(negedge clk);
        cmd_v[1] = 4'b1000; mc_rdy[1] = 1'b1; #1;
        check("fix 3 hdr", mc_hdr[1],       64'hA3);
        check("fix 3 rdy", 64'(cmd_rdy[1]), 4'b1000);
        @(negedge clk);
        cmd_v[1] = 4'b0001; #1;
        check("full mc_v", 64'(mc_v[1]),    0);
        check("full rdy",  64'(cmd_rdy[1]), 0);
        @(negedge clk);
        mr_v[1] = 1'b1; mr_last[1] = 1'b0; #1;
        check("full resp0 v",  64'(resp_v[1]), 4'b0010);
        check("full resp0 rdy",64'(mr_rdy[1]), 1);
        check("full resp0 mc", 64'(mc_v[1]),   0);
        @(negedge clk);
        mr_last[1] = 1'b1; #1;
        check("full resp1 v",  64'(resp_v[1]), 4'b0010);
        check("pop no unblock",64'(mc_v[1]),   0);
        @(negedge clk);
        mr_v[1] = 1'b0; #1;
        check("after pop mc_v", 64'(mc_v[1]),    1);
        check("after pop hdr",  mc_hdr[1],       64'hA0);
        check("after pop rdy",  64'(cmd_rdy[1]), 4'b0001);
        @(negedge clk);
        cmd_v[1] = '0;

        // Response routing: issue 3,0,2 then return responses in order with channel 0 stalling
        do_reset();
        cmd_v[0] = 4'b1000; #1;
        check("iss 3 rdy", 64'(cmd_rdy[0]), 4'b1000);
        @(negedge clk);
        cmd_v[0] = 4'b0001; #1;
        check("iss 0 rdy", 64'(cmd_rdy[0]), 4'b0001);
        @(negedge clk);
        cmd_v[0] = 4'b0100; #1;
        check("iss 2 rdy", 64'(cmd_rdy[0]), 4'b0100);
        @(negedge clk);
        cmd_v[0] = '0; resp_rdy[0] = 4'b1110;
        mr_v[0] = 1'b1; mr_last[0] = 1'b1; mr_data[0] = 64'h33; #1;
        check("route 3 v",    64'(resp_v[0]), 4'b1000);
        check("route 3 rdy",  64'(mr_rdy[0]), 1);
        check("route 3 data", resp_data[0],   64'h33);
        @(negedge clk);
        mr_data[0] = 64'h30;
        for (int s = 0; s < 5; s++) begin
            #1;
            check($sformatf("route 0 stall v %0d", s),   64'(resp_v[0]), 4'b0001);
            check($sformatf("route 0 stall rdy %0d", s), 64'(mr_rdy[0]), 0);
            @(negedge clk);
        end
        resp_rdy[0] = 4'hF; #1;
        check("route 0 v",   64'(resp_v[0]), 4'b0001);
        check("route 0 rdy", 64'(mr_rdy[0]), 1);
        @(negedge clk);
        mr_data[0] = 64'h32; #1;
        check("route 2 v",    64'(resp_v[0]), 4'b0100);
        check("route 2 rdy",  64'(mr_rdy[0]), 1);
        check("route 2 data", resp_data[0],   64'h32);
        @(negedge clk);
        mr_v[0] = 1'b0; #1;
        check("route done rdy", 64'(mr_rdy[0]), 0);
        check("route done v",   64'(resp_v[0]), 0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
